addr_seq_gen: RTL

//  Parametrised address sequencer for the memory checker data path. On start it

---
 rtl/addr_seq_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/addr_seq_gen.sv
// addr_seq_gen: generates FIX/RND/RUN_0/RUN_1/INC/DEC address streams over valid/ready,
// with wrap-around, LFSR seeding, transfer count, abort and done/error status.
module addr_seq_gen #(
    parameter int ADDR_W = 28,
    parameter int CNT_W  = 32,
    parameter int LFSR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [2:0]        mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic [CNT_W-1:0]  addr_cnt_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [2:0] M_FIX = 3'd0, M_RND = 3'd1, M_RUN_0 = 3'd2, M_RUN_1 = 3'd3,
                           M_INC = 3'd4, M_DEC = 3'd5;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [2:0]        mode;
    logic [ADDR_W-1:0] base, last, first, next;
    logic [CNT_W-1:0]  cnt;
    logic [LFSR_W-1:0] lfsr, lfsr_nxt, seed;
    logic              fb, legal, xfer;

    generate
        if (LFSR_W == 8) begin : g_fb8
            assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        end else if (LFSR_W == 16) begin : g_fb16
            assign fb = lfsr[15] ^ lfsr[7] ^ lfsr[1];
        end else begin : g_fb32
            assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
        end
    endgenerate

    assign lfsr_nxt = {lfsr[LFSR_W-2:0], fb};
    assign seed     = (seed_i == '0) ? '1 : seed_i;
    assign xfer     = addr_valid_o & addr_ready_i;
    assign legal    = (mode_i <= M_DEC) &&
                      !((mode_i == M_INC || mode_i == M_DEC) && base_addr_i > last_addr_i);
    assign first = (mode_i == M_RND)   ? seed[ADDR_W-1:0] :
                   (mode_i == M_RUN_0) ? ~ONE :
                   (mode_i == M_RUN_1) ? ONE :
                   (mode_i == M_DEC)   ? last_addr_i : base_addr_i;
    // wrap is tested before the +/-1 so the arithmetic never leaves [base, last]
    assign next = (mode == M_RND) ? lfsr_nxt[ADDR_W-1:0] :
                  (mode == M_RUN_0 || mode == M_RUN_1) ? {addr_o[ADDR_W-2:0], addr_o[ADDR_W-1]} :
                  (mode == M_INC) ? ((addr_o == last) ? base : addr_o + ONE) :
                  (mode == M_DEC) ? ((addr_o == base) ? last : addr_o - ONE) : base;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            mode         <= M_FIX;
            base         <= '0;
            last         <= '0;
            cnt          <= '0;
            lfsr         <= '1;
            addr_o       <= '0;
            addr_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state        <= IDLE;
                addr_valid_o <= 1'b0;
                busy_o       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        if (!legal) begin
                            err_o <= 1'b1;
                        end else begin
                            err_o  <= 1'b0;
                            mode   <= mode_i;
                            base   <= base_addr_i;
                            last   <= last_addr_i;
                            cnt    <= addr_cnt_i;
                            lfsr   <= seed;
                            addr_o <= first;
                            if (addr_cnt_i == '0) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                state        <= RUN;
                                addr_valid_o <= 1'b1;
                                busy_o       <= 1'b1;
                            end
                        end
                    end
                    RUN: if (xfer) begin
                        cnt  <= cnt - CNT_ONE;
                        lfsr <= lfsr_nxt;
                        if (cnt == CNT_ONE) begin
                            state        <= DONE;
                            addr_valid_o <= 1'b0;
                            busy_o       <= 1'b0;
                            done_o       <= 1'b1;
                        end else begin
                            addr_o <= next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
